// File: rtl/chip8_scanout.sv
// rtl/chip8_scanout.sv - CHIP-8 64x32 framebuffer to 640x480@60 VGA scanout with line prefetch
module chip8_scanout #(
    parameter logic [23:0] FG_RGB    = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB    = 24'h000000,
    parameter int          V_VISIBLE = 480,
    parameter int          V_FRONT   = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 33,
    parameter int          WIN_TOP   = 80,
    parameter int          ROW_SCALE = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       disp_ram_req,
    output logic [7:0] scan_a,
    input  logic [7:0] scan_q,
    input  logic       underrun_clr,
    output logic       underrun,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);

    localparam int         V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] HS_START = 10'd656;
    localparam logic [9:0] HS_END   = 10'd752;
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] W_TOP    = 10'(WIN_TOP);
    localparam logic [9:0] W_END    = 10'(WIN_TOP + 32 * ROW_SCALE);
    localparam logic [3:0] SUB_LAST = 4'(ROW_SCALE - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t          state, state_nxt;
    logic            pix_en;
    logic [9:0]      hc, vc, next_vc;
    logic [3:0]      hsub, vsub;
    logic [6:0]      hcol;
    logic [4:0]      vrow, next_row, fetch_row;
    logic [3:0]      byte_idx;
    logic [2:0]      cap_idx, cap_cnt;
    logic            cap_vld;
    logic [7:0][7:0] disp_buf, fetch_buf;
    logic [23:0]     rgb;
    logic            wrap, start, issue, next_in_win, in_win, vis, pix_bit;

    assign next_vc     = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
    assign next_in_win = (next_vc >= W_TOP) && (next_vc < W_END);
    // Row of the upcoming line, derived from the row sub-counters rather than a divide
    assign next_row    = (next_vc == W_TOP) ? 5'd0 :
                         (vsub == SUB_LAST) ? vrow + 5'd1 : vrow;
    assign in_win      = (vc >= W_TOP) && (vc < W_END);
    assign vis         = (hc < H_VIS) && (vc < V_VIS);
    assign pix_bit     = disp_buf[hcol[5:3]][~hcol[2:0]];
    assign wrap        = pix_en && (hc == H_LAST);
    assign start       = (state == IDLE) && (hc == H_VIS) && next_in_win;
    assign issue       = (state == FETCH) && !disp_ram_req && !byte_idx[3];
    assign {vga_r, vga_g, vga_b} = rgb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH: begin
                if (wrap)                             state_nxt = IDLE;
                else if (cap_vld && cap_cnt == 3'd7)  state_nxt = DONE;
            end
            DONE:    if (wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_en      <= 1'b0;
            hc          <= '0;
            vc          <= '0;
            hsub        <= '0;
            hcol        <= '0;
            vsub        <= '0;
            vrow        <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            rgb         <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                if (hc == H_LAST) begin
                    hc   <= '0;
                    hsub <= '0;
                    hcol <= '0;
                    vc   <= next_vc;
                    if (next_vc == W_TOP) begin
                        vsub <= '0;
                        vrow <= '0;
                    end else if (vsub == SUB_LAST) begin
                        vsub <= '0;
                        vrow <= vrow + 5'd1;
                    end else begin
                        vsub <= vsub + 4'd1;
                    end
                end else begin
                    hc <= hc + 10'd1;
                    if (hsub == 4'd9) begin
                        hsub <= '0;
                        hcol <= hcol + 7'd1;
                    end else begin
                        hsub <= hsub + 4'd1;
                    end
                end
                vga_hs      <= !((hc >= HS_START) && (hc < HS_END));
                vga_vs      <= !((vc >= VS_START) && (vc < VS_END));
                vga_blank_n <= vis;
                rgb         <= !vis ? 24'd0 : (in_win && pix_bit) ? FG_RGB : BG_RGB;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_a    <= '0;
            byte_idx  <= '0;
            cap_idx   <= '0;
            cap_cnt   <= '0;
            cap_vld   <= 1'b0;
            fetch_row <= '0;
            fetch_buf <= '0;
            disp_buf  <= '0;
            underrun  <= 1'b0;
        end else begin
            if (start) begin
                byte_idx  <= '0;
                cap_cnt   <= '0;
                fetch_row <= next_row;
            end
            if (issue) begin
                scan_a   <= {fetch_row, byte_idx[2:0]};
                cap_idx  <= byte_idx[2:0];
                byte_idx <= byte_idx + 4'd1;
            end
            cap_vld <= issue;
            if (cap_vld) begin
                fetch_buf[cap_idx] <= scan_q;
                cap_cnt            <= cap_cnt + 3'd1;
            end
            // A fetch still running at the line wrap is dropped; the old line stays on screen
            if (wrap && state == DONE) disp_buf <= fetch_buf;
            if (wrap && state == FETCH) underrun <= 1'b1;
            else if (underrun_clr)      underrun <= 1'b0;
        end
    end

endmodule
